inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning instruction buffer entries (power of two, at least 2).
REQ-003 SHALL have one clock and asynchronous active-high reset; ports named CLK and RST.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 redirect  input  1  load a new fetch PC this cycle (branch/jal/jalr taken).
REQ-007 redirect_pc  input  32  new fetch PC; bits [1:0] ignored.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  word-aligned request address.
REQ-010 imem_gnt  input  1  request accepted this cycle.
REQ-011 imem_rvalid  input  1  read data valid; at most one response per grant, in order, latency 1 or more cycles.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 inst_valid  output  1  buffer head holds a valid instruction.
REQ-014 inst  output  32  head instruction.
REQ-015 inst_pc  output  32  PC of the head instruction.
REQ-016 inst_ready  input  1  decoder consumes the head when inst_valid is high.

Function
REQ-017 SHALL keep at most one outstanding request (granted, no rvalid yet).
REQ-018 SHALL assert imem_req only when occupancy plus outstanding is less than BUF_DEPTH and the state is not DRAIN.
REQ-019 Once asserted, imem_req and imem_addr SHALL hold stable until imem_gnt; the only exception is redirect, which abandons an ungranted request.
REQ-020 On grant, fetch_pc SHALL advance by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-021 A new request MAY issue in the same cycle as imem_rvalid, giving a sustained throughput of one instruction per cycle when gnt is same-cycle and rvalid arrives next cycle.
REQ-022 On rvalid in RUN, SHALL push {pc, rdata}; inst_valid SHALL rise on the cycle after rvalid.
REQ-023 Pop SHALL occur when inst_valid and inst_ready are both high; simultaneous push and pop SHALL be allowed even when the buffer is full.
REQ-024 inst and inst_pc SHALL be stable while inst_valid is high and inst_ready is low.
REQ-025 FSM states SHALL be RUN, WAIT and DRAIN. RUN means no outstanding request. WAIT means an outstanding request exists. DRAIN means the outstanding response must be discarded.
REQ-026 FSM transitions SHALL be:
- RUN to WAIT on gnt.
- WAIT to RUN on rvalid without a new gnt.
- WAIT stays in WAIT on rvalid with a new gnt.
- WAIT to DRAIN on redirect.
- DRAIN to RUN on rvalid.
REQ-027 On redirect, the buffer SHALL be flushed, fetch_pc SHALL load {redirect_pc[31:2], 2'b00}, and inst_valid SHALL be low on the next cycle.
REQ-028 Redirect SHALL take priority over a simultaneous pop.
REQ-029 Redirect SHALL take priority over a simultaneous rvalid, and that response SHALL be dropped.
REQ-030 While in DRAIN, imem_req SHALL be low. The first request to redirect_pc SHALL issue on the cycle after the discarded rvalid.
REQ-031 A redirect during DRAIN SHALL update fetch_pc and remain in DRAIN.
REQ-032 rvalid in RUN with no outstanding request is illegal and SHALL be ignored.

Reset
REQ-033 Reset values SHALL be: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, FSM=RUN, occupancy=0, fetch_pc=RESET_PC.
REQ-034 Assertion of RST mid-transaction SHALL abandon any outstanding response.
REQ-035 The first imem_req SHALL assert in the first cycle after RST deasserts.
REQ-036 The memory is also reset by RST, so no stale rvalid follows reset.

Structure
REQ-037 The shared package shrv_pkg SHALL hold:
- the fetch state enum (RUN, WAIT, DRAIN);
- the NOP encoding constant;
- the default RESET_PC;
- the fetch_entry_t struct {pc, inst}.
REQ-038 The buffer SHALL be a sub-module fetch_fifo. It has parameterised depth, registered storage, push, pop, flush, full, empty and count, and same-cycle push+pop when full.
REQ-039 The FSM, PC and handshake logic SHALL reside in inst_fetch.

Verification
REQ-040 Reset release, gnt always high, 1-cycle rvalid latency, ready always high: SHALL show inst_pc sequence 0,4,8,C on consecutive cycles, first inst_valid 2 cycles after the first req.
REQ-041 ready held low with BUF_DEPTH=2: SHALL stop imem_req after two fills; raising ready SHALL resume requests immediately at PC 8.
REQ-042 gnt withheld 3 cycles: SHALL hold imem_addr at 0x10 unchanged with req high throughout.
REQ-043 Redirect to 0x203 while in WAIT: SHALL drop the pending rvalid, deassert req for DRAIN, then fetch from 0x200; no instruction from the old stream appears.
REQ-044 Redirect to 0x80 in the same cycle as rvalid and pop: SHALL keep inst_valid low next cycle, with the next inst_pc equal to 0x80.
REQ-045 RESET_PC=32'hFFFF_FFF8: SHALL produce inst_pc sequence FFFFFFF8, FFFFFFFC, 0, 4.

Source files
------------

// File: rtl/shrv_pkg.sv
// Shared types for the front end: fetch FSM states, NOP encoding,
// default reset PC and the buffered {pc, inst} entry.
package shrv_pkg;

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    DRAIN
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch bus bundle: imem req/gnt/rvalid side and decoder valid/ready side.
// master = fetch unit; slave = memory plus decoder.
interface inst_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry ring of {pc, inst}; push/pop/flush,
// full/empty/count; push while full is accepted when a pop happens too.
module fetch_fifo
  import shrv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic do_push;
  logic do_pop;

  assign empty = (count == '0);
  assign full = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, RUN/WAIT/DRAIN FSM, imem handshake, buffer.
// Ports: CLK, RST, redirect, redirect_pc, bus (inst_fetch_if.master).
module inst_fetch
  import shrv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  inst_fetch_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] SLOT_MAX = (CW + 1)'(BUF_DEPTH);

  fetch_state_e state;
  fetch_state_e state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_nxt;

  logic [CW-1:0] count;
  logic full;
  logic empty;
  fetch_entry_t head;
  fetch_entry_t wr_entry;

  logic pending;
  logic pop;
  logic push;
  logic req;
  logic grant;
  logic [CW:0] slots;

  assign pending = (state == WAIT);
  assign pop = !empty && bus.inst_ready;

  // Buffered plus in-flight entries, counting this cycle's pop as
  // already gone so a consumed slot can be refetched at once.
  assign slots = {1'b0, count}
               + (CW + 1)'(pending)
               - (CW + 1)'(pop);

  // In WAIT a new request may only go out alongside the returning
  // rvalid, keeping a single outstanding grant. Redirect drops any
  // ungranted request so the stale address is never accepted.
  assign req = !RST && !redirect
            && (state == RUN || (pending && bus.imem_rvalid))
            && (slots < SLOT_MAX);
  assign grant = req && bus.imem_gnt;

  assign push = pending && bus.imem_rvalid && !redirect
             && (!full || pop);

  assign wr_entry.pc = fetch_pc - 32'd4;
  assign wr_entry.inst = bus.imem_rdata;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fetch_pc_nxt = fetch_pc;

    unique case (1'b1)
      redirect: fetch_pc_nxt = redirect_pc & ~32'h3;
      grant: fetch_pc_nxt = fetch_pc + 32'd4;
      default: fetch_pc_nxt = fetch_pc;
    endcase

    unique case (state)
      RUN: begin
        if (grant) state_nxt = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          state_nxt = bus.imem_rvalid ? RUN : DRAIN;
        end else if (bus.imem_rvalid) begin
          state_nxt = grant ? WAIT : RUN;
        end
      end
      DRAIN: begin
        if (bus.imem_rvalid) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  fetch_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .CLK  (CLK),
    .RST  (RST),
    .push (push),
    .pop  (pop),
    .flush(redirect),
    .wdata(wr_entry),
    .rdata(head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  assign bus.imem_req = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.inst_valid = !empty;
  assign bus.inst = empty ? NOP_INST : head.inst;
  assign bus.inst_pc = empty ? RESET_PC : head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory responder, scoreboard of granted fetches,
// directed scenarios, a wrapping-PC instance and a random phase.
module tb_inst_fetch;
  import shrv_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  logic redirect;
  logic [31:0] redirect_pc;
  logic ready;
  logic gnt_en;
  logic [1:0] lat;

  int n_chk = 0;
  int n_err = 0;

  inst_fetch_if bus();
  inst_fetch_if wbus();

  inst_fetch dut (
    .CLK        (CLK),
    .RST        (RST),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .bus        (bus)
  );

  inst_fetch #(
    .RESET_PC(32'hFFFF_FFF8)
  ) dut_w (
    .CLK        (CLK),
    .RST        (RST),
    .redirect   (1'b0),
    .redirect_pc(32'h0),
    .bus        (wbus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // main memory: gnt gated by gnt_en, response after lat cycles
  logic [1:0] resp_cnt;
  logic [31:0] resp_addr;

  assign bus.imem_gnt = bus.imem_req && gnt_en;
  assign bus.imem_rvalid = (resp_cnt == 2'd1);
  assign bus.imem_rdata = bus.imem_rvalid ? mem_word(resp_addr)
                                          : 32'hDEAD_BEEF;
  assign bus.inst_ready = ready;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_cnt <= 2'd0;
      resp_addr <= 32'h0;
    end else if (bus.imem_req && bus.imem_gnt) begin
      resp_cnt <= lat;
      resp_addr <= bus.imem_addr;
    end else if (resp_cnt != 2'd0) begin
      resp_cnt <= resp_cnt - 2'd1;
    end
  end

  // wrap instance memory: gnt always, one-cycle latency
  logic w_cnt;
  logic [31:0] w_addr;

  assign wbus.imem_gnt = wbus.imem_req;
  assign wbus.imem_rvalid = w_cnt;
  assign wbus.imem_rdata = mem_word(w_addr);
  assign wbus.inst_ready = 1'b1;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_cnt <= 1'b0;
      w_addr <= 32'h0;
    end else begin
      w_cnt <= wbus.imem_req && wbus.imem_gnt;
      w_addr <= wbus.imem_addr;
    end
  end

  // scoreboard: push on grant, clear on redirect, compare on pop
  fetch_entry_t sb[$];
  logic prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  always begin
    fetch_entry_t e;
    @(negedge CLK);
    #4;
    if (RST) begin
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && !redirect) begin
        chk("req_hold", 32'(bus.imem_req), 32'd1);
        chk("addr_hold", bus.imem_addr, prev_addr);
      end
      if (bus.imem_req)
        chk("addr_align", {30'b0, bus.imem_addr[1:0]}, 32'd0);
      if (resp_cnt == 2'd2)
        chk("one_outstanding", 32'(bus.imem_req), 32'd0);
      if (redirect) begin
        chk("req_on_redirect", 32'(bus.imem_req), 32'd0);
        sb.delete();
      end else begin
        if (bus.inst_valid && bus.inst_ready) begin
          if (sb.size() == 0) begin
            chk("sb_level", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            chk("inst_pc", bus.inst_pc, e.pc);
            chk("inst", bus.inst, e.inst);
          end
        end
        if (bus.imem_req && bus.imem_gnt) begin
          e.pc = bus.imem_addr;
          e.inst = mem_word(bus.imem_addr);
          sb.push_back(e);
        end
      end
      prev_hold = bus.imem_req && !bus.imem_gnt && !redirect;
      prev_addr = bus.imem_addr;
    end
  end

  task automatic step();
    @(negedge CLK);
    #4;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    redirect = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #4;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] pc);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.inst_valid) begin
        seen = 1;
        break;
      end
      step();
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_pc"}, bus.inst_pc, pc);
  endtask

  logic [31:0] wexp [4];

  initial begin
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    wexp[3] = 32'h0000_0004;
    RST = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    ready = 1'b1;
    gnt_en = 1'b1;
    lat = 2'd1;

    // reset values
    repeat (2) @(negedge CLK);
    #4;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'h0000_0013);
    chk("rst_pc", bus.inst_pc, 32'h0);
    chk("rst_w_addr", wbus.imem_addr, 32'hFFFF_FFF8);
    chk("rst_w_pc", wbus.inst_pc, 32'hFFFF_FFF8);

    // streaming, plus wrap on the second instance
    @(negedge CLK);
    RST = 1'b0;
    #4;
    chk("s1_req0", 32'(bus.imem_req), 32'd1);
    chk("s1_addr0", bus.imem_addr, 32'h0);
    chk("s1_valid0", 32'(bus.inst_valid), 32'd0);
    chk("w_req0", 32'(wbus.imem_req), 32'd1);
    step();
    chk("s1_valid1", 32'(bus.inst_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("s1_valid", 32'(bus.inst_valid), 32'd1);
      chk("s1_pc", bus.inst_pc, 32'(4 * k));
      chk("w_valid", 32'(wbus.inst_valid), 32'd1);
      chk("w_pc", wbus.inst_pc, wexp[k]);
    end

    // ready low: two fills then stall, resume at 8
    ready = 1'b0;
    do_reset();
    chk("s2_req0", 32'(bus.imem_req), 32'd1);
    chk("s2_addr0", bus.imem_addr, 32'h0);
    step();
    chk("s2_req1", 32'(bus.imem_req), 32'd1);
    chk("s2_addr1", bus.imem_addr, 32'h4);
    step();
    chk("s2_req2", 32'(bus.imem_req), 32'd0);
    chk("s2_valid2", 32'(bus.inst_valid), 32'd1);
    step();
    chk("s2_req3", 32'(bus.imem_req), 32'd0);
    step();
    chk("s2_req4", 32'(bus.imem_req), 32'd0);
    chk("s2_pc4", bus.inst_pc, 32'h0);
    @(negedge CLK);
    ready = 1'b1;
    #4;
    chk("s2_resume_req", 32'(bus.imem_req), 32'd1);
    chk("s2_resume_addr", bus.imem_addr, 32'h8);
    repeat (6) step();

    // gnt withheld three cycles at 0x10
    do_reset();
    begin
      bit found = 0;
      for (int i = 0; i < 40; i++) begin
        if (bus.imem_req && bus.imem_gnt && bus.imem_addr == 32'hC) begin
          found = 1;
          break;
        end
        step();
      end
      chk("s3_reach_c", 32'(found), 32'd1);
    end
    @(negedge CLK);
    gnt_en = 1'b0;
    #4;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      chk("s3_hold_req", 32'(bus.imem_req), 32'd1);
      chk("s3_hold_addr", bus.imem_addr, 32'h10);
    end
    @(negedge CLK);
    gnt_en = 1'b1;
    #4;
    chk("s3_gnt_addr", bus.imem_addr, 32'h10);
    step();
    chk("s3_next_addr", bus.imem_addr, 32'h14);
    repeat (4) step();

    // redirect in WAIT -> DRAIN -> fetch 0x200
    lat = 2'd2;
    do_reset();
    chk("s4_req0", 32'(bus.imem_req), 32'd1);
    @(negedge CLK);
    redirect = 1'b1;
    redirect_pc = 32'h203;
    #4;
    chk("s4_req_wait", 32'(bus.imem_req), 32'd0);
    @(negedge CLK);
    redirect = 1'b0;
    #4;
    chk("s4_drain_rvalid", 32'(bus.imem_rvalid), 32'd1);
    chk("s4_drain_req", 32'(bus.imem_req), 32'd0);
    chk("s4_drain_valid", 32'(bus.inst_valid), 32'd0);
    step();
    chk("s4_req_new", 32'(bus.imem_req), 32'd1);
    chk("s4_addr_new", bus.imem_addr, 32'h200);
    wait_valid("s4_first", 32'h200);

    // redirect together with rvalid and pop
    lat = 2'd1;
    do_reset();
    step();
    @(negedge CLK);
    redirect = 1'b1;
    redirect_pc = 32'h80;
    #4;
    chk("s5_rvalid", 32'(bus.imem_rvalid), 32'd1);
    chk("s5_pop", 32'(bus.inst_valid), 32'd1);
    @(negedge CLK);
    redirect = 1'b0;
    #4;
    chk("s5_valid_low", 32'(bus.inst_valid), 32'd0);
    chk("s5_req", 32'(bus.imem_req), 32'd1);
    chk("s5_addr", bus.imem_addr, 32'h80);
    wait_valid("s5_first", 32'h80);

    // random traffic, checked by the scoreboard
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      gnt_en = ($urandom_range(0, 3) != 0);
      ready = ($urandom_range(0, 3) != 0);
      lat = 2'($urandom_range(1, 2));
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      #4;
    end
    @(negedge CLK);
    redirect = 1'b0;
    gnt_en = 1'b1;
    ready = 1'b1;
    #4;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
